// File: rtl/interleave_pkg.sv
// Shared types and default widths for the interleave probe sequencer.
package interleave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int DEF_VW       = 10;
  localparam int DEF_NW       = 4;
  localparam int DEF_SETTLE_W = 4;
  localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/interleave_settle_cnt.sv
// Settle-cycle counter: loads a count, decrements toward zero, flags zero.
module interleave_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/interleave_probe_seq.sv
// Drives one stimulus bit into an observed fan-out, snapshots it before and
// after a settle delay, and returns the pair as a record over valid/ready.
module interleave_probe_seq
  import interleave_pkg::*;
#(
  parameter int VW       = DEF_VW,
  parameter int NW       = DEF_NW,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stim_val,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                abort,
  output logic                stim,
  input  logic [VW-1:0]       obs_v,
  input  logic [NW-1:0]       obs_n,
  output logic                busy,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [VW-1:0]       rec_before_v,
  output logic [VW-1:0]       rec_after_v,
  output logic [NW-1:0]       rec_before_n,
  output logic [NW-1:0]       rec_after_n,
  output logic [VW+NW-1:0]    rec_changed,
  output logic                rec_stim,
  output logic [CNT_W-1:0]    run_count,
  output state_t              dbg_state
);

  // Record handshake: a record transfers on any rising edge where
  // rec_valid && rec_ready are both high; rec_valid, once raised, stays high
  // and the record fields stay frozen until that transfer or an abort/reset.

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_n;
  logic   accept, capture, complete, drop;
  logic   cnt_load, cnt_dec, cnt_zero;

  interleave_settle_cnt #(.W(SETTLE_W)) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (settle),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        // An abort in IDLE masks a simultaneous start.
        if (start && !abort) begin
          accept  = 1'b1;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt_zero) begin
          capture = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_n = IDLE;
        end else if (rec_ready) begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cnt_load  = accept;
  assign drop      = (state != IDLE) && (state_n == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim         <= 1'b0;
      rec_stim     <= 1'b0;
      rec_before_v <= '0;
      rec_before_n <= '0;
      rec_after_v  <= '0;
      rec_after_n  <= '0;
      rec_changed  <= '0;
      rec_valid    <= 1'b0;
      run_count    <= '0;
    end else begin
      if (accept) begin
        rec_before_v <= obs_v;
        rec_before_n <= obs_n;
        stim         <= stim_val;
        rec_stim     <= stim_val;
      end
      if (capture) begin
        rec_after_v <= obs_v;
        rec_after_n <= obs_n;
        rec_changed <= {obs_n ^ rec_before_n, obs_v ^ rec_before_v};
        rec_valid   <= 1'b1;
      end else if (drop) begin
        rec_valid <= 1'b0;
      end
      if (complete && (run_count != CNT_MAX)) begin
        run_count <= run_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/interleave_probe_seq.md
# interleave_probe_seq

Sequencer that exercises a combinational fan-out under observation (continuous assigns, gate primitives, `always_comb`/`@(*)` blocks, for both variable and net targets) from a single stimulus bit. It snapshots every observed output before and after a stimulus change, waits a programmable number of settle cycles, and returns one record per run over a valid/ready handshake. It sits between the bench/host and the observed fan-out, and it owns the fan-out's input.

## Interface
- VW, 10, width of the observed variable vector
- NW, 4, width of the observed net vector
- SETTLE_W, 4, width of the settle-cycle count
- CNT_W, 8, width of the run counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request a run; sampled only in IDLE
- stim_val  in  1  stimulus value to apply for this run
- settle  in  SETTLE_W  extra settle cycles before the after-capture
- abort  in  1  synchronous cancel of the current run
- stim  out  1  registered drive into the observed fan-out
- obs_v  in  VW  observed variable outputs
- obs_n  in  NW  observed net outputs
- busy  out  1  state != IDLE
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_before_v / rec_after_v  out  VW  variable snapshots
- rec_before_n / rec_after_n  out  NW  net snapshots
- rec_changed  out  VW+NW  {after_n^before_n, after_v^before_v}
- rec_stim  out  1  stimulus value of this record
- run_count  out  CNT_W  completed runs, saturating

## Operation
- States: IDLE, SETTLE, HOLD.
- IDLE & start: before_v/before_n <= obs_v/obs_n; stim <= stim_val; rec_stim <= stim_val; cnt <= settle; go SETTLE.
- SETTLE: cnt != 0 -> cnt--; cnt == 0 -> after_v/after_n <= obs, rec_changed <= XOR mask, rec_valid <= 1, go HOLD.
- HOLD: record outputs are stable while rec_valid=1. rec_ready=1 -> rec_valid <= 0, run_count++ (saturates at 2^CNT_W-1), go IDLE.
- abort=1 in SETTLE or HOLD -> IDLE, rec_valid <= 0, no count increment. Abort wins over rec_ready in the same cycle. abort in IDLE is a no-op, and start in the same cycle is ignored.
- stim holds its last applied value across runs and abort; the next run's before-snapshot reflects it.
- start while busy is ignored, not queued. The edge that returns the FSM to IDLE does not sample start.
- Record registers keep their last contents after handshake; only rec_valid qualifies them.
- Reset values: state IDLE, stim 0, rec_valid 0, all record fields 0, run_count 0, cnt 0, busy 0.
- Reset mid-run: immediate return to reset values; the in-flight record is lost.

## Timing
- Edge 0: start accepted; stim changes after edge 0.
- After-capture occurs on edge settle+1. rec_valid is high after that edge, giving a latency of settle+1 cycles. With settle=0, obs is sampled one full cycle after stim changes.
- Back-to-back minimum: handshake edge, then start accepted on the following edge. Period is settle+3 cycles with rec_ready held high.
- obs inputs must be combinational from stim within one cycle. The block adds no synchronizers.

## Structure
- interleave_pkg: state enum typedef (IDLE, SETTLE, HOLD); default-width localparams.
- One sub-module: interleave_settle_cnt (load/decrement/zero-flag counter, SETTLE_W wide).
- Top holds the FSM, snapshot registers, XOR mask and run counter (~150–250 RTL lines).

## Test plan
- Reset, obs_v=10'h000, obs_n=4'h0; start, stim_val=1, settle=0, obs follows as v=10'h155, n=4'h5 -> rec_valid 1 cycle after start; before=000/0, after=155/5, rec_changed=14'h1555 (={4'h5,10'h155}), rec_stim=1, run_count=1 after handshake.
- settle=5, rec_ready held 1 -> rec_valid rises exactly 6 cycles after start; busy high for 7 cycles.
- rec_ready low for 10 cycles in HOLD, obs changing meanwhile -> record fields unchanged; start pulses ignored; run_count unchanged until ready.
- abort asserted in SETTLE, then in HOLD together with rec_ready -> IDLE both times, rec_valid 0, run_count unchanged, stim keeps the applied value.
- rst_n asserted mid-SETTLE with stim=1 -> stim=0, busy=0, rec_valid=0 asynchronously; a subsequent run behaves as after reset.
- With CNT_W=2, run 5 completed runs -> run_count saturates at 3.
